act_unit: RTL

Multi-lane, mode-selectable activation stage for the datapath, placed directly after the MAC/accumulate stage. It applies bypass, ReLU, leaky ReLU or clipped ReLU to `LANES` signed fixed-point values per beat. A two-stage valid/ready pipeline sustains one beat per cycle under backpressure. A saturating counter records how many lane values were clamped to zero.

---
 rtl/act_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/act_unit.sv
// act_unit: multi-lane activation stage (bypass / ReLU / leaky ReLU / clipped ReLU)
// placed after the MAC stage. Two-register valid/ready pipeline: stage A captures
// the beat and its mode/clip settings, stage B holds the activated result. A
// saturating counter accumulates how many lanes were clamped to zero.
module act_unit #(
  parameter int DATA_W      = 13,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       clip_max,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        zero_cnt
);

  typedef enum logic [1:0] {
    ModeBypass = 2'd0,
    ModeRelu   = 2'd1,
    ModeLeaky  = 2'd2,
    ModeClip   = 2'd3
  } act_mode_e;

  // Width of a per-beat clamped-lane count (0..LANES).
  localparam int CW = $clog2(LANES + 1) + 1;

  // Clears the clip bound's sign bit so the clip limit is never negative.
  localparam logic [DATA_W-1:0] MAG_MASK = {1'b0, {(DATA_W-1){1'b1}}};

  // Per-lane activation; every mode keeps the result inside DATA_W bits.
  function automatic logic [DATA_W-1:0] actLane(
    input logic signed [DATA_W-1:0] x,
    input act_mode_e                m,
    input logic signed [DATA_W-1:0] lim
  );
    logic [DATA_W-1:0] y;
    y = x;
    case (m)
      ModeBypass: y = x;
      ModeRelu: begin
        if (x[DATA_W-1]) y = '0;
      end
      ModeLeaky: begin
        if (x[DATA_W-1]) y = x >>> LEAKY_SHIFT;
      end
      ModeClip: begin
        if (x[DATA_W-1])  y = '0;
        else if (x > lim) y = lim;
      end
      default: y = x;
    endcase
    return y;
  endfunction

  // Stage A registers (captured input beat and its sampled settings)
  logic                    vA_q, vA_d;
  logic [LANES*DATA_W-1:0] dataA_q, dataA_d;
  act_mode_e               modeA_q, modeA_d;
  logic [DATA_W-1:0]       clipA_q, clipA_d;

  // Stage B registers (activated result and clamp flags travelling with it)
  logic                    vB_q, vB_d;
  logic [LANES*DATA_W-1:0] dataB_q, dataB_d;
  logic [LANES-1:0]        clampB_q, clampB_d;

  // Clamp counter
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Pipeline control and datapath intermediates
  logic                    advA, advB, inFire, outFire;
  logic signed [DATA_W-1:0] clipLimit;
  logic [LANES*DATA_W-1:0] actData;
  logic [LANES-1:0]        actClamp;
  logic [CW-1:0]           clampCount;
  logic [CNT_W:0]          cntSum;

  assign advB      = !vB_q || out_ready;
  assign advA      = !vA_q || advB;
  assign in_ready  = advA;
  assign inFire    = in_valid && in_ready;
  assign out_valid = vB_q;
  assign out_data  = dataB_q;
  assign outFire   = vB_q && out_ready;
  assign zero_cnt  = cnt_q;

  // Activation of the stage A beat and its per-lane clamp flags.
  always_comb begin
    actData   = '0;
    actClamp  = '0;
    clipLimit = clipA_q & MAG_MASK;
    for (int i = 0; i < LANES; i++) begin
      actData[i*DATA_W +: DATA_W] =
        actLane($signed(dataA_q[i*DATA_W +: DATA_W]), modeA_q, clipLimit);
      actClamp[i] = ((modeA_q == ModeRelu) || (modeA_q == ModeClip)) &&
                    dataA_q[i*DATA_W + DATA_W - 1];
    end
  end

  // Stage A next state: load on input handshake, empty when drained without refill.
  always_comb begin
    vA_d    = vA_q;
    dataA_d = dataA_q;
    modeA_d = modeA_q;
    clipA_d = clipA_q;
    if (advA) begin
      vA_d = inFire;
      if (inFire) begin
        dataA_d = in_data;
        modeA_d = act_mode_e'(mode);
        clipA_d = clip_max;
      end
    end
  end

  // Stage B next state: take the activated beat from A whenever B may advance.
  always_comb begin
    vB_d     = vB_q;
    dataB_d  = dataB_q;
    clampB_d = clampB_q;
    if (advB) begin
      vB_d = vA_q;
      if (vA_q) begin
        dataB_d  = actData;
        clampB_d = actClamp;
      end
    end
  end

  // Counter next state: add clamped lanes on output handshake, saturate, clear wins.
  always_comb begin
    clampCount = '0;
    for (int i = 0; i < LANES; i++) begin
      clampCount = clampCount + CW'(clampB_q[i]);
    end
    cntSum = {1'b0, cnt_q} + (CNT_W+1)'(clampCount);
    cnt_d  = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (outFire) begin
      cnt_d = cntSum[CNT_W] ? {CNT_W{1'b1}} : cntSum[CNT_W-1:0];
    end
  end

  // Stage A register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vA_q    <= 1'b0;
      dataA_q <= '0;
      modeA_q <= ModeBypass;
      clipA_q <= '0;
    end else begin
      vA_q    <= vA_d;
      dataA_q <= dataA_d;
      modeA_q <= modeA_d;
      clipA_q <= clipA_d;
    end
  end

  // Stage B register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vB_q     <= 1'b0;
      dataB_q  <= '0;
      clampB_q <= '0;
    end else begin
      vB_q     <= vB_d;
      dataB_q  <= dataB_d;
      clampB_q <= clampB_d;
    end
  end

  // Clamp counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
